// File: rtl/ws_systolic_core.sv
// ws_systolic_core: weight-stationary ROWS x COLS MAC array with on-chip activation
// skew, output deskew, double-buffered weights and a swap that waits for an empty pipe.
module ws_systolic_core #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b1,
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_act_vec,
  input  logic                   w_load_en,
  input  logic [IDX_W-1:0]       w_row_idx,
  input  logic [COLS*DATA_W-1:0] in_weight_vec,
  input  logic                   w_swap,
  output logic                   swap_pending,
  output logic                   busy,
  output logic                   out_valid,
  output logic [COLS*ACC_W-1:0]  out_psum_vec
);
  localparam int LAT = ROWS + COLS + 1;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [IDX_W:0] ROWS_L = (IDX_W + 1)'(ROWS);

  typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

  state_t            state_r, state_n;
  logic              swap_go_s;
  logic              accept_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [LAT-1:0]    vld_r;
  logic              bank_sel_r;
  logic [DATA_W-1:0] bank_r     [2][ROWS][COLS];
  logic [DATA_W-1:0] in_act_r   [ROWS];
  logic [DATA_W-1:0] skew_act_s [ROWS];
  logic [DATA_W-1:0] act_pe_r   [ROWS][COLS];
  logic [ACC_W-1:0]  psum_r     [ROWS][COLS];
  logic [ACC_W-1:0]  mac_s      [ROWS][COLS];
  logic [ACC_W-1:0]  deskew_s   [COLS];

  // Full-width product, sign- or zero-extended (or wrapped) to the accumulator width
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sp;
    logic [2*DATA_W-1:0]        up;
    sp = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    up = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    if (SIGNED) return ACC_W'(sp);
    else        return ACC_W'(up);
  endfunction

  assign accept_s     = in_valid && in_ready;
  assign in_ready     = (state_r == ST_RUN);
  assign swap_pending = (state_r == ST_PEND);
  assign busy         = (cnt_r != '0);

  // Input capture, valid pipeline and in-flight count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) in_act_r[r] <= '0;
      vld_r <= '0;
      cnt_r <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        in_act_r[r] <= accept_s ? in_act_vec[r*DATA_W +: DATA_W] : '0;
      vld_r <= {vld_r[LAT-2:0], accept_s};
      if (accept_s && !vld_r[LAT-1])      cnt_r <= cnt_r + CNT_W'(1);
      else if (!accept_s && vld_r[LAT-1]) cnt_r <= cnt_r - CNT_W'(1);
      else                                cnt_r <= cnt_r;
    end
  end

  // Swap state and weight banks; loads always target the bank that is shadow before the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      bank_sel_r <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) bank_r[b][r][c] <= '0;
    end else begin
      state_r <= state_n;
      if (w_load_en && ({1'b0, w_row_idx} < ROWS_L))
        for (int c = 0; c < COLS; c++)
          bank_r[~bank_sel_r][w_row_idx][c] <= in_weight_vec[c*DATA_W +: DATA_W];
      if (swap_go_s) bank_sel_r <= ~bank_sel_r;
    end
  end

  // Next-state logic: a requested swap waits until nothing is in flight
  always_comb begin
    state_n   = state_r;
    swap_go_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (w_swap) state_n = ST_PEND;
        else        state_n = ST_RUN;
      end
      ST_PEND: begin
        if ((cnt_r == '0) && !accept_s) begin
          state_n   = ST_RUN;
          swap_go_s = 1'b1;
        end else begin
          state_n = ST_PEND;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign skew_act_s[r] = in_act_r[r];
    end else begin : g_delay
      logic [DATA_W-1:0] dly_r [r];
      // Row r enters the array r cycles late
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) dly_r[i] <= '0;
        end else begin
          dly_r[0] <= in_act_r[r];
          for (int i = 1; i < r; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign skew_act_s[r] = dly_r[r-1];
    end
  end

  // Each PE adds its product to the partial sum arriving from the row above
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        mac_s[r][c] = ((r == 0) ? '0 : psum_r[(r == 0) ? 0 : r - 1][c])
                    + mul_ext(act_pe_r[r][c], bank_sel_r ? bank_r[1][r][c] : bank_r[0][r][c]);
      end
    end
  end

  // PE registers: activations move right, partial sums move down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          act_pe_r[r][c] <= '0;
          psum_r[r][c]   <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          act_pe_r[r][c] <= (c == 0) ? skew_act_s[r] : act_pe_r[r][(c == 0) ? 0 : c - 1];
          psum_r[r][c]   <= mac_s[r][c];
        end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign deskew_s[c] = psum_r[ROWS-1][c];
    end else begin : g_delay
      logic [ACC_W-1:0] dly_r [D];
      // Early columns wait so that all columns leave together
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dly_r[i] <= '0;
        end else begin
          dly_r[0] <= psum_r[ROWS-1][c];
          for (int i = 1; i < D; i++) dly_r[i] <= dly_r[i-1];
        end
      end
      assign deskew_s[c] = dly_r[D-1];
    end
  end

  // Output register holds the last result between valid cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_psum_vec <= '0;
    end else begin
      out_valid <= vld_r[LAT-1];
      if (vld_r[LAT-1])
        for (int c = 0; c < COLS; c++) out_psum_vec[c*ACC_W +: ACC_W] <= deskew_s[c];
    end
  end
endmodule

// File: tb/tb_ws_systolic_core.sv
// Bench for ws_systolic_core: three instances (unsigned/32, signed/32, unsigned/16) share
// one stimulus stream and are checked against an edge-level queue model of the core.
module tb_ws_systolic_core;
  localparam int R = 4, C = 4, DW = 8, LAT = R + C + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0, w_load_en = 1'b0, w_swap = 1'b0;
  logic [R*DW-1:0] in_act_vec = '0;
  logic [C*DW-1:0] in_weight_vec = '0;
  logic [1:0]      w_row_idx = '0;
  logic [2:0]      rdy, pend, bsy, ov;
  logic [C*32-1:0] ps_u, ps_s;
  logic [C*16-1:0] ps_w;

  int n_chk = 0, n_err = 0, edge_n = 0;

  // model state: weight banks, bank select, pending flag, expected results with due edge
  logic [DW-1:0]   mw [2][R][C];
  bit              msel = 1'b0, mpend = 1'b0;
  int              due_q[$];
  logic [C*32-1:0] eu_q[$], es_q[$];
  logic [C*32-1:0] last_u = '0, last_s = '0;
  logic [C*16-1:0] last_w = '0;

  typedef struct {
    logic [31:0] act;
    logic [7:0]  wf;
    logic [31:0] eu;
    logic [31:0] es;
    logic [15:0] ew;
  } vec_t;
  vec_t tbl [6];

  ws_systolic_core #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_act_vec(in_act_vec),
    .w_load_en(w_load_en), .w_row_idx(w_row_idx), .in_weight_vec(in_weight_vec), .w_swap(w_swap),
    .swap_pending(pend[0]), .busy(bsy[0]), .out_valid(ov[0]), .out_psum_vec(ps_u));
  ws_systolic_core #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(32), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_act_vec(in_act_vec),
    .w_load_en(w_load_en), .w_row_idx(w_row_idx), .in_weight_vec(in_weight_vec), .w_swap(w_swap),
    .swap_pending(pend[1]), .busy(bsy[1]), .out_valid(ov[1]), .out_psum_vec(ps_s));
  ws_systolic_core #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16), .SIGNED(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_act_vec(in_act_vec),
    .w_load_en(w_load_en), .w_row_idx(w_row_idx), .in_weight_vec(in_weight_vec), .w_swap(w_swap),
    .swap_pending(pend[2]), .busy(bsy[2]), .out_valid(ov[2]), .out_psum_vec(ps_w));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [C*32-1:0] ref_vec(input logic [R*DW-1:0] act, input bit sgn, input bit bank);
    logic [C*32-1:0] v;
    longint          s;
    logic [DW-1:0]   a, w;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++) begin
        a = act[r*DW +: DW];
        w = mw[bank][r][c];
        if (sgn) s += longint'($signed(a)) * longint'($signed(w));
        else     s += longint'(a) * longint'(w);
      end
      v[c*32 +: 32] = s[31:0];
    end
    return v;
  endfunction

  function automatic logic [C*16-1:0] narrow(input logic [C*32-1:0] v);
    logic [C*16-1:0] n;
    for (int c = 0; c < C; c++) n[c*16 +: 16] = v[c*32 +: 16];
    return n;
  endfunction

  task automatic check_outputs();
    bit exp_ov;
    exp_ov = (due_q.size() > 0) && (due_q[0] == edge_n);
    if (exp_ov) begin
      void'(due_q.pop_front());
      last_u = eu_q.pop_front();
      last_s = es_q.pop_front();
      last_w = narrow(last_u);
    end
    chk("out_valid", ov, {3{exp_ov}});
    chk("in_ready", rdy, {3{!mpend}});
    chk("swap_pending", pend, {3{mpend}});
    chk("busy", bsy, {3{due_q.size() != 0}});
    chk("psum_unsigned", ps_u, last_u);
    chk("psum_signed", ps_s, last_s);
    chk("psum_wrap16", ps_w, last_w);
  endtask

  // apply the model for the coming edge, clock it, then compare
  task automatic tick();
    bit acc;
    int cnt_before;
    acc        = in_valid && !mpend;
    cnt_before = due_q.size();
    edge_n++;
    if (acc) begin
      due_q.push_back(edge_n + LAT);
      eu_q.push_back(ref_vec(in_act_vec, 1'b0, msel));
      es_q.push_back(ref_vec(in_act_vec, 1'b1, msel));
    end
    if (w_load_en)
      for (int c = 0; c < C; c++) mw[!msel][w_row_idx][c] = in_weight_vec[c*DW +: DW];
    if (!mpend) mpend = w_swap;
    else if (cnt_before == 0) begin
      mpend = 1'b0;
      msel  = !msel;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; w_load_en = 1'b0; w_swap = 1'b0;
    due_q.delete(); eu_q.delete(); es_q.delete();
    mw = '{default: '0};
    msel = 1'b0; mpend = 1'b0;
    last_u = '0; last_s = '0; last_w = '0;
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3*LAT && due_q.size() != 0; i++) tick();
    tick();
  endtask

  task automatic load_all(input logic [C*DW-1:0] wrow, input bit do_swap);
    for (int r = 0; r < R; r++) begin
      w_load_en = 1'b1; w_row_idx = 2'(r); in_weight_vec = wrow;
      tick();
    end
    w_load_en = 1'b0;
    if (do_swap) begin
      w_swap = 1'b1;
      tick();
      w_swap = 1'b0;
      chk("swap_enter", {pend[0], rdy[0]}, 2'b10);
      tick();
      chk("swap_exit", {pend[0], rdy[0]}, 2'b01);
    end
  endtask

  task automatic send(input logic [R*DW-1:0] act);
    in_valid = 1'b1; in_act_vec = act;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!ov[0] && n < 30) begin
      tick();
      n++;
    end
    chk("out_valid_timeout", ov[0], 1'b1);
  endtask

  initial begin
    int n, seen;
    tbl[0] = '{32'h80808080, 8'h80, 32'h00010000, 32'h00010000, 16'h0000};
    tbl[1] = '{32'hFFFFFFFF, 8'hFF, 32'd260100,    32'd4,        16'd63492};
    tbl[2] = '{32'h04030201, 8'h02, 32'd20,        32'd20,       16'd20};
    tbl[3] = '{32'h7F7F7F7F, 8'h81, 32'd65532,     32'hFFFF03FC, 16'hFFFC};
    tbl[4] = '{32'h00000000, 8'h55, 32'd0,         32'd0,        16'd0};
    tbl[5] = '{32'h01FF0280, 8'hFE, 32'h00017EFC,  32'h000000FC, 16'h7EFC};

    do_reset();
    chk("reset_flags", {ov[0], rdy[0], pend[0], bsy[0]}, 4'b0100);
    chk("reset_psum", ps_u, '0);

    // basic result and latency
    load_all({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    send(32'h04030201);
    wait_ov(n);
    chk("latency", n, LAT);
    chk("basic_psum", ps_u, {32'd40, 32'd30, 32'd20, 32'd10});

    // back-to-back throughput
    drain();
    for (int a = 1; a <= 4; a++) begin
      in_valid = 1'b1; in_act_vec = {4{8'(a)}};
      tick();
    end
    in_valid = 1'b0;
    wait_ov(n);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", ov[0], 1'b1);
      chk("b2b_col0", ps_u[31:0], 32'(4*(i+1)));
      tick();
    end

    // swap guard: A in flight when the swap is requested
    drain();
    load_all({4{8'd3}}, 1'b0);
    send(32'h01010101);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    n = 0;
    while (!ov[0] && n < 30) begin
      chk("guard_ready_low", rdy[0], 1'b0);
      tick();
      n++;
    end
    chk("guard_a_valid", ov[0], 1'b1);
    chk("guard_a_old_w", ps_u, {32'd16, 32'd12, 32'd8, 32'd4});
    chk("guard_ready_at_out", rdy[0], 1'b0);
    chk("guard_busy_at_swap", bsy[0], 1'b0);
    tick();
    chk("guard_ready_after", {pend[0], rdy[0]}, 2'b01);
    send(32'h01010101);
    wait_ov(n);
    chk("guard_b_new_w", ps_u, {4{32'd12}});

    // table of signed/unsigned/wrap corner vectors
    for (int i = 0; i < 6; i++) begin
      drain();
      load_all({4{tbl[i].wf}}, 1'b1);
      send(tbl[i].act);
      wait_ov(n);
      chk("tbl_unsigned", ps_u, {4{tbl[i].eu}});
      chk("tbl_signed", ps_s, {4{tbl[i].es}});
      chk("tbl_wrap16", ps_w, {4{tbl[i].ew}});
    end

    // randomized traffic with loads and swaps at arbitrary times
    drain();
    for (int i = 0; i < 800; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      in_act_vec    = $urandom;
      w_load_en     = ($urandom_range(0, 3) == 0);
      w_row_idx     = 2'($urandom_range(0, 3));
      in_weight_vec = $urandom;
      w_swap        = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; w_load_en = 1'b0; w_swap = 1'b0;
    drain();

    // reset in the middle of traffic with a swap pending
    in_valid = 1'b1; in_act_vec = 32'h05060708;
    tick();
    tick();
    in_valid = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    tick();
    do_reset();
    chk("rst_mid_flags", {ov[0], rdy[0], pend[0]}, 3'b010);
    chk("rst_mid_psum", ps_u, '0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen += int'(ov[0]);
    end
    chk("rst_no_valid_after", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
